// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI minion slice.
//   state_t          : FSM state encoding (IDLE, ACTIVE)
//   SPI_SYNC_STAGES  : number of flops in each pin synchronizer chain
//   cnt_width()      : width of a bit counter that must hold 0..n+1
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int SPI_SYNC_STAGES = 2;

    // The frame counter saturates one past the frame width so that an
    // over-long frame remains distinguishable from a correct one.
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// ---------------------------------------------------------------------------
// spi_sync
// One-bit synchronizer for an asynchronous SPI pin, followed by an edge
// detector. The pin passes through SPI_SYNC_STAGES flops, then one more flop
// holds the previous synchronized value for edge detection.
//
// Ports
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   din    in   asynchronous pin
//   level  out  synchronized pin level
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition
//
// Parameter
//   RESET_VAL  value loaded into every flop on reset; matches the idle level
//              of the pin so that no false edge appears after reset.
// ---------------------------------------------------------------------------
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SPI_SYNC_STAGES-1:0] sync_q;
    logic                       prev_q;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop in the chain samples the value from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SPI_SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SPI_SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SPI_SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_minion.sv
// ---------------------------------------------------------------------------
// spi_minion
// SPI mode 0 (CPOL=0, CPHA=0) minion, MSB first, full duplex. All SPI pins
// are oversampled by clk (at least 8x sclk); every pin goes through spi_sync,
// so pin edges are acted on three clk cycles after they occur.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   cs         in   chip select, active low (asynchronous)
//   sclk       in   serial clock (asynchronous)
//   mosi       in   serial data from the master
//   miso       out  serial data to the master; 0 while idle
//   send_msg   in   word loaded for transmission when a frame starts
//   send_rdy   out  pulse: send_msg captured this cycle
//   recv_msg   out  last correctly framed word, held until the next one
//   recv_val   out  pulse: recv_msg updated
//   frame_err  out  pulse: frame ended with a bit count other than nbits
//
// Parameter
//   nbits      frame width, 2..64
// ---------------------------------------------------------------------------
module spi_minion
    import spi_pkg::*;
#(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    input  logic [nbits-1:0] send_msg,
    output logic             send_rdy,
    output logic [nbits-1:0] recv_msg,
    output logic             recv_val,
    output logic             frame_err
);

    localparam int             CW       = cnt_width(nbits);
    localparam logic [CW-1:0]  CNT_FULL = CW'(nbits);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(nbits + 1);

    // -----------------------------------------------------------------
    // Pin synchronizers. cs idles high, sclk and mosi idle low; the
    // flops reset to those levels. Outputs nobody needs are named
    // *_unused.
    // -----------------------------------------------------------------
    logic cs_rise, cs_fall, cs_level_unused;
    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .din   (cs),
        .level (cs_level_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // mosi has the same synchronizer latency as sclk, so the level seen
    // alongside a detected sclk rise is the bit the master set up for it.
    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .din   (mosi),
        .level (mosi_s),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    // -----------------------------------------------------------------
    // Frame FSM, shift register and bit counter. All outputs are
    // registered; the three status pulses default low every cycle and
    // are set in mutually exclusive branches, so they are one cycle wide
    // and never coincide.
    // -----------------------------------------------------------------
    state_t            state;
    logic [nbits-1:0]  shreg;
    logic [CW-1:0]     bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            recv_msg  <= '0;
            miso      <= 1'b0;
            send_rdy  <= 1'b0;
            recv_val  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            send_rdy  <= 1'b0;
            recv_val  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        shreg    <= send_msg;
                        // The first bit must be on miso before the first
                        // sclk rise, so it comes straight from send_msg.
                        miso     <= send_msg[nbits-1];
                        bit_cnt  <= '0;
                        send_rdy <= 1'b1;
                    end
                end

                ACTIVE: begin
                    if (cs_rise) begin
                        // End of frame takes priority over any sclk edge
                        // detected in the same cycle.
                        state <= IDLE;
                        miso  <= 1'b0;
                        if (bit_cnt == CNT_FULL) begin
                            recv_msg <= shreg;
                            recv_val <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            shreg <= {shreg[nbits-2:0], mosi_s};
                            if (bit_cnt != CNT_SAT) begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        // After a rise the MSB already holds the next bit
                        // to transmit; present it on the following fall.
                        if (sclk_fall) begin
                            miso <= shreg[nbits-1];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    miso  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_minion.sv
// ---------------------------------------------------------------------------
// tb_spi_minion
// Directed bench for spi_minion with nbits = 8 and clk = 10x sclk. A table
// of frames (tx/rx words, bit count, expected results) is played by a mode 0
// master model; hand-written sequences cover reset, idle sclk activity,
// coincident cs/sclk edges and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_spi_minion;

    localparam int NB   = 8;
    localparam int HALF = 5;    // clk cycles per sclk half period

    logic          clk = 1'b0;
    logic          reset;
    logic          cs;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic [NB-1:0] send_msg;
    logic          send_rdy;
    logic [NB-1:0] recv_msg;
    logic          recv_val;
    logic          frame_err;

    always #5 clk = ~clk;

    spi_minion #(.nbits(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .send_msg  (send_msg),
        .send_rdy  (send_rdy),
        .recv_msg  (recv_msg),
        .recv_val  (recv_val),
        .frame_err (frame_err)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------------------------------------------------------
    // Output monitor: counts pulses, flags overlapping or stretched
    // pulses, and flags miso high once cs has been high for a while.
    // ---------------------------------------------------------------
    int   rdy_cnt = 0, val_cnt = 0, err_cnt = 0;
    int   overlap_cnt = 0, stretch_cnt = 0, idle_miso_bad = 0;
    int   cs_high_run = 0;
    logic prev_rdy = 1'b0, prev_val = 1'b0, prev_err = 1'b0;

    always @(negedge clk) begin
        if (send_rdy === 1'b1) rdy_cnt++;
        if (recv_val === 1'b1) val_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if ((int'(send_rdy === 1'b1) + int'(recv_val === 1'b1) + int'(frame_err === 1'b1)) > 1)
            overlap_cnt++;
        if ((send_rdy === 1'b1 && prev_rdy) || (recv_val === 1'b1 && prev_val) ||
            (frame_err === 1'b1 && prev_err))
            stretch_cnt++;
        prev_rdy = (send_rdy === 1'b1);
        prev_val = (recv_val === 1'b1);
        prev_err = (frame_err === 1'b1);
        cs_high_run = (cs === 1'b1) ? cs_high_run + 1 : 0;
        if (cs_high_run > 5 && miso === 1'b1) idle_miso_bad++;
    end

    // ---------------------------------------------------------------
    // Master model
    // ---------------------------------------------------------------
    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    // Shifts n bits MSB first; bits past the word width are sent as 0.
    // miso is sampled at each sclk rise. Ends with sclk low.
    task automatic shift_bits(input int n, input logic [NB-1:0] tx, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = (i < NB) ? tx[NB-1-i] : 1'b0;
            half_period();
            sclk = 1'b1;
            rx   = {rx[14:0], miso};
            half_period();
            sclk = 1'b0;
        end
    endtask

    // Waits (bounded) for recv_val or frame_err after cs rises.
    task automatic wait_end(input string name, output int lat);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (recv_val === 1'b1 || frame_err === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({name, " end latency"}, lat, 3);
    endtask

    typedef struct {
        logic [NB-1:0] send;
        logic [NB-1:0] tx;
        int            nb;
        logic [15:0]   exp_miso;
        logic [NB-1:0] exp_recv;
        int            exp_val;
        int            exp_err;
    } vec_t;

    task automatic run_frame(input string name, input vec_t v);
        int          r0, v0, e0, lat, exp_cnt;
        logic [15:0] rx;
        r0 = rdy_cnt; v0 = val_cnt; e0 = err_cnt;
        send_msg = v.send;
        cs = 1'b0;
        shift_bits(v.nb, v.tx, rx);
        half_period();
        exp_cnt = (v.nb > NB + 1) ? NB + 1 : v.nb;
        check({name, " bit_cnt"}, 32'(dut.bit_cnt), exp_cnt);
        cs = 1'b1;
        wait_end(name, lat);
        repeat (2 * 2 * HALF - lat) @(negedge clk);
        check({name, " miso"}, rx, v.exp_miso);
        check({name, " recv_msg"}, recv_msg, v.exp_recv);
        check({name, " recv_val"}, val_cnt - v0, v.exp_val);
        check({name, " frame_err"}, err_cnt - e0, v.exp_err);
        check({name, " send_rdy"}, rdy_cnt - r0, 1);
    endtask

    vec_t vecs[7];

    initial begin
        int          r0, v0, e0, lat;
        logic [15:0] rx;
        logic [NB-1:0] msg0;
        vec_t        tail;

        //              send   tx     nb  miso      recv   val err
        vecs[0] = '{8'hA5, 8'h3C, 8,  16'h00A5, 8'h3C, 1, 0};  // full duplex
        vecs[1] = '{8'h00, 8'hC3, 8,  16'h0000, 8'hC3, 1, 0};
        vecs[2] = '{8'hFF, 8'h5A, 7,  16'h007F, 8'hC3, 0, 1};  // short
        vecs[3] = '{8'h81, 8'h55, 9,  16'h0102, 8'hC3, 0, 1};  // long
        vecs[4] = '{8'h3C, 8'h01, 8,  16'h003C, 8'h01, 1, 0};  // back-to-back
        vecs[5] = '{8'hC3, 8'hFF, 8,  16'h00C3, 8'hFF, 1, 0};
        vecs[6] = '{8'h0F, 8'h96, 11, 16'h007C, 8'hFF, 0, 1};  // saturation

        reset    = 1'b1;
        cs       = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        send_msg = '0;
        repeat (3) @(negedge clk);
        check("reset miso", miso, 0);
        check("reset recv_msg", recv_msg, 0);
        check("reset pulses", {send_rdy, recv_val, frame_err}, 0);
        check("reset bit_cnt", 32'(dut.bit_cnt), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post-reset no pulses", rdy_cnt + val_cnt + err_cnt, 0);

        // sclk activity with cs high must be ignored
        r0 = rdy_cnt; v0 = val_cnt; e0 = err_cnt; msg0 = recv_msg;
        send_msg = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            half_period();
            sclk = 1'b1;
            check("idle sclk miso", miso, 0);
            half_period();
            sclk = 1'b0;
        end
        repeat (10) @(negedge clk);
        check("idle sclk pulses", (rdy_cnt - r0) + (val_cnt - v0) + (err_cnt - e0), 0);
        check("idle sclk recv_msg", recv_msg, msg0);
        mosi = 1'b0;

        for (int i = 0; i < 7; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        // cs rise and sclk rise land together: the sclk edge is dropped
        r0 = rdy_cnt; v0 = val_cnt; e0 = err_cnt;
        send_msg = 8'h33;
        cs = 1'b0;
        shift_bits(NB, 8'hE7, rx);
        half_period();
        sclk = 1'b1;
        cs   = 1'b1;
        wait_end("coincident", lat);
        sclk = 1'b0;
        repeat (20) @(negedge clk);
        check("coincident miso", rx, 16'h0033);
        check("coincident recv_msg", recv_msg, 8'hE7);
        check("coincident recv_val", val_cnt - v0, 1);
        check("coincident frame_err", err_cnt - e0, 0);

        // reset after 4 bits, released with cs low, then 4 more bits
        r0 = rdy_cnt; v0 = val_cnt; e0 = err_cnt;
        send_msg = 8'h11;
        cs = 1'b0;
        shift_bits(4, 8'hF0, rx);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid-frame reset recv_msg", recv_msg, 0);
        check("mid-frame reset pulses", (val_cnt - v0) + (err_cnt - e0), 0);
        reset = 1'b0;
        shift_bits(4, 8'hF0, rx);
        half_period();
        cs = 1'b1;
        wait_end("after reset", lat);
        repeat (20) @(negedge clk);
        check("after reset recv_val", val_cnt - v0, 0);
        check("after reset frame_err", err_cnt - e0, 1);
        check("after reset send_rdy", rdy_cnt - r0, 2);
        check("after reset recv_msg", recv_msg, 0);

        tail = '{8'hC8, 8'h5A, 8, 16'h00C8, 8'h5A, 1, 0};
        run_frame("post-reset frame", tail);

        check("pulse overlap", overlap_cnt, 0);
        check("pulse stretch", stretch_cnt, 0);
        check("idle miso", idle_miso_bad, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_minion.md
SPI_MINION -- requirements
Module: spi_minion

Interface
REQ-001 Parameter: nbits, default 32, frame width in bits; legal range 2..64.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cs  in  1  SPI chip select, active low, asynchronous to clk.
REQ-005 sclk  in  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 mosi  in  1  SPI data in, MSB first.
REQ-007 miso  out  1  SPI data out, MSB first.
REQ-008 send_msg  in  nbits  word to transmit in the next frame.
REQ-009 send_rdy  out  1  one-cycle pulse: send_msg captured this cycle.
REQ-010 recv_msg  out  nbits  last correctly received word; held until next valid frame.
REQ-011 recv_val  out  1  one-cycle pulse: recv_msg updated with a complete frame.
REQ-012 frame_err  out  1  one-cycle pulse: frame ended with bit count != nbits.

Function
REQ-013 cs, sclk and mosi SHALL each pass through two synchronizing flops, then one edge-detect flop; edges are detected 3 clk cycles after the pin transition.
REQ-014 Correct operation SHALL be required only when the clk frequency is at least 8x the sclk frequency.
REQ-015 FSM states SHALL be IDLE and ACTIVE.
REQ-016 In IDLE, a detected cs falling edge SHALL do all of the following in that cycle: go to ACTIVE, load send_msg into the nbits shift register, drive miso from send_msg[nbits-1], clear the bit counter, and pulse send_rdy.
REQ-017 In ACTIVE, each detected sclk rising edge SHALL shift the synchronized mosi into the shift register LSB (shift left) and increment the bit counter.
REQ-018 The bit counter SHALL saturate at nbits+1.
REQ-019 In ACTIVE, each detected sclk falling edge SHALL set miso to the shift register MSB.
REQ-020 In ACTIVE, a detected cs rising edge SHALL return the FSM to IDLE.
REQ-021 On that cs rising edge, if the bit counter == nbits, the shift register SHALL be copied to recv_msg and recv_val pulsed; otherwise frame_err SHALL be pulsed and recv_msg left unchanged.
REQ-022 A cs rising edge and an sclk edge detected in the same cycle: the cs edge SHALL win and the sclk edge SHALL be ignored.
REQ-023 sclk edges SHALL be ignored in IDLE.
REQ-024 miso SHALL be held at 0 in IDLE.
REQ-025 recv_val, send_rdy and frame_err SHALL never be asserted in the same cycle as each other.
REQ-026 recv_val, send_rdy and frame_err SHALL never stay high longer than one cycle.
REQ-027 No backpressure: the downstream consumer SHALL capture recv_msg on recv_val; a later valid frame overwrites recv_msg.

Reset
REQ-028 On reset: FSM to IDLE; shift register, counter, recv_msg, miso, recv_val, send_rdy and frame_err to 0.
REQ-029 On reset: cs synchronizer flops to 1; sclk and mosi synchronizer flops to 0.
REQ-030 Reset mid-frame SHALL discard the frame with no recv_val and no frame_err.
REQ-031 If cs is low at reset release, the resulting partial frame SHALL terminate with frame_err unless exactly nbits sclk rising edges follow.

Structure
REQ-032 Shared package spi_pkg SHALL hold the FSM state typedef (IDLE, ACTIVE) and the constant SPI_SYNC_STAGES = 2.
REQ-033 Sub-module spi_sync SHALL implement one-bit synchronizer plus edge detect; outputs: synchronized level, rise pulse, fall pulse.
REQ-034 spi_minion SHALL instantiate spi_sync three times (cs, sclk, mosi).
REQ-035 The shift register, counter and FSM SHALL reside in spi_minion.

Verification (nbits=8, clk = 10x sclk)
REQ-036 Full-duplex frame: send_msg=0xA5, master sends 0x3C -> send_rdy pulses once; master reads 0xA5 on miso; recv_msg=0x3C; recv_val pulses once about 3 clk after cs rise.
REQ-037 Short frame: 7 sclk pulses, then cs high -> frame_err pulses; recv_msg keeps its prior value; no recv_val.
REQ-038 Long frame: 9 sclk pulses -> frame_err pulses; counter saturates at 9; no recv_val.
REQ-039 Back-to-back frames 0x01 then 0xFF with 2 sclk periods of cs high between them -> two recv_val pulses with recv_msg 0x01 then 0xFF; send_rdy pulses twice.
REQ-040 Reset asserted after bit 4 of a frame, released with cs still low, then 4 more bits -> no recv_val; frame_err pulses at cs rise; the next full frame 0x5A is received correctly.
REQ-041 sclk toggling with cs high -> no outputs change; miso stays 0.
